reg_bus_hub: RTL and testbench

Parametrised register-bus interconnect between the address decoder (bus master) and N register targets: the clock handler, the UART, the channel processors and future blocks. It replaces the fixed 3-input OR combining of ack/data_out/data_out_valid. It decodes each request to exactly one target through a mask/match map and forwards it with a held strobe. It collects the single response, generates error responses for unmapped addresses, timeouts and stray acks, and buffers one request while busy.

---
 rtl/reg_bus_hub.sv | 192 +++++++++++++++++++
 tb/tb_reg_bus_hub.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_hub.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_hub
// Purpose  : Register-bus interconnect: mask/match decode to one of N targets,
//            held strobe, single response collection, error/drop accounting.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bus_hub #(
    parameter int N_TARGETS = 3,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int TIMEOUT   = 8,
    parameter logic [N_TARGETS*ADDR_W-1:0] MASK  = {N_TARGETS{4'hC}},
    parameter logic [N_TARGETS*ADDR_W-1:0] MATCH = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m_valid,
    input  logic [ADDR_W-1:0]             m_addr,
    input  logic [DATA_W-1:0]             m_data,
    output logic                          m_ready,
    output logic                          m_ack,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_rvalid,
    output logic                          m_err,
    output logic [N_TARGETS-1:0]          t_valid,
    output logic [ADDR_W-1:0]             t_addr,
    output logic [DATA_W-1:0]             t_data,
    input  logic [N_TARGETS-1:0]          t_ack,
    input  logic [N_TARGETS*DATA_W-1:0]   t_rdata,
    input  logic [N_TARGETS-1:0]          t_rvalid,
    output logic [7:0]                    err_count
);

    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_stray;
    logic                   r_pend_valid;
    logic [ADDR_W-1:0]      r_pend_addr;
    logic [DATA_W-1:0]      r_pend_data;
    logic                   r_m_ack;
    logic [DATA_W-1:0]      r_m_rdata;
    logic                   r_m_rvalid;
    logic                   r_m_err;
    logic [N_TARGETS-1:0]   r_t_valid;
    logic [ADDR_W-1:0]      r_t_addr;
    logic [DATA_W-1:0]      r_t_data;
    logic [7:0]             r_err_count;

    logic                   w_can_load;
    logic [ADDR_W-1:0]      w_load_addr;
    logic [DATA_W-1:0]      w_load_data;
    logic [N_TARGETS-1:0]   w_dec;
    logic                   w_sel_ack;
    logic                   w_stray;
    logic                   w_timeout;
    logic [DATA_W-1:0]      w_sel_rdata;
    logic                   w_sel_rvalid;
    logic                   w_err_set;
    logic                   w_drop;
    logic [8:0]             w_err_sum;

    // A buffered request always has priority over a new one arriving in RESP;
    // the new one is then dropped because the slot is still full.
    assign w_can_load  = ((r_state == S_IDLE) && m_valid) ||
                         ((r_state == S_RESP) && (r_pend_valid || m_valid));
    assign w_load_addr = r_pend_valid ? r_pend_addr : m_addr;
    assign w_load_data = r_pend_valid ? r_pend_data : m_data;

    // Descending scan so the lowest-index match is the one left standing.
    always_comb begin
        w_dec = '0;
        for (int i = N_TARGETS - 1; i >= 0; i--) begin
            if ((w_load_addr & MASK[i*ADDR_W +: ADDR_W]) == MATCH[i*ADDR_W +: ADDR_W]) begin
                w_dec    = '0;
                w_dec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_rdata  = '0;
        w_sel_rvalid = 1'b0;
        for (int i = 0; i < N_TARGETS; i++) begin
            if (r_t_valid[i]) begin
                w_sel_rdata  = t_rdata[i*DATA_W +: DATA_W];
                w_sel_rvalid = t_rvalid[i];
            end
        end
    end

    assign w_sel_ack = (r_state == S_REQ) && |(t_ack & r_t_valid);
    assign w_stray   = (r_state == S_REQ) && |(t_ack & ~r_t_valid);
    assign w_timeout = (r_state == S_REQ) && (TIMEOUT != 0) && !w_sel_ack && (r_cnt == c_TO_LAST);
    assign w_err_set = (w_can_load && (w_dec == '0)) || w_timeout ||
                       (w_sel_ack && (r_stray || w_stray));
    assign w_drop    = m_valid && r_pend_valid;
    assign w_err_sum = {1'b0, r_err_count} + {8'd0, w_err_set} + {8'd0, w_drop};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_stray      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_m_ack      <= 1'b0;
            r_m_rdata    <= '0;
            r_m_rvalid   <= 1'b0;
            r_m_err      <= 1'b0;
            r_t_valid    <= '0;
            r_t_addr     <= '0;
            r_t_data     <= '0;
            r_err_count  <= '0;
        end else begin
            r_m_ack     <= 1'b0;
            r_m_rdata   <= '0;
            r_m_rvalid  <= 1'b0;
            r_m_err     <= 1'b0;
            r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_can_load) begin
                        r_t_addr     <= w_load_addr;
                        r_t_data     <= w_load_data;
                        r_pend_valid <= 1'b0;
                        r_stray      <= 1'b0;
                        r_cnt        <= '0;
                        if (w_dec != '0) begin
                            r_t_valid <= w_dec;
                            r_state   <= S_REQ;
                        end else begin
                            r_m_ack <= 1'b1;
                            r_m_err <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (m_valid && !r_pend_valid) begin
                        r_pend_valid <= 1'b1;
                        r_pend_addr  <= m_addr;
                        r_pend_data  <= m_data;
                    end
                    if (w_stray) begin
                        r_stray <= 1'b1;
                    end
                    if (w_sel_ack) begin
                        r_t_valid  <= '0;
                        r_m_ack    <= 1'b1;
                        r_m_rvalid <= w_sel_rvalid;
                        r_m_rdata  <= w_sel_rvalid ? w_sel_rdata : '0;
                        r_m_err    <= r_stray || w_stray;
                        r_state    <= S_RESP;
                    end else if (w_timeout) begin
                        r_t_valid <= '0;
                        r_m_ack   <= 1'b1;
                        r_m_err   <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_ready   = ~r_pend_valid;
    assign m_ack     = r_m_ack;
    assign m_rdata   = r_m_rdata;
    assign m_rvalid  = r_m_rvalid;
    assign m_err     = r_m_err;
    assign t_valid   = r_t_valid;
    assign t_addr    = r_t_addr;
    assign t_data    = r_t_data;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_hub.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bus_hub
// Purpose  : Directed self-checking bench for reg_bus_hub (3 targets, timeout 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bus_hub;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid;
    logic [3:0]  m_addr;
    logic [3:0]  m_data;
    logic        m_ready;
    logic        m_ack;
    logic [3:0]  m_rdata;
    logic        m_rvalid;
    logic        m_err;
    logic [2:0]  t_valid;
    logic [3:0]  t_addr;
    logic [3:0]  t_data;
    logic [2:0]  t_ack;
    logic [11:0] t_rdata;
    logic [2:0]  t_rvalid;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_bus_hub #(
        .N_TARGETS (3),
        .ADDR_W    (4),
        .DATA_W    (4),
        .TIMEOUT   (8),
        .MASK      ({4'h8, 4'hC, 4'hC}),
        .MATCH     ({4'h8, 4'h4, 4'h0})
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata),
        .m_rvalid  (m_rvalid),
        .m_err     (m_err),
        .t_valid   (t_valid),
        .t_addr    (t_addr),
        .t_data    (t_data),
        .t_ack     (t_ack),
        .t_rdata   (t_rdata),
        .t_rvalid  (t_rvalid),
        .err_count (err_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ready"}, {31'd0, m_ready}, 32'd1);
        check_val({tag, "_ack"}, {31'd0, m_ack}, 32'd0);
        check_val({tag, "_rdata"}, {28'd0, m_rdata}, 32'd0);
        check_val({tag, "_rvalid"}, {31'd0, m_rvalid}, 32'd0);
        check_val({tag, "_err"}, {31'd0, m_err}, 32'd0);
        check_val({tag, "_tvalid"}, {29'd0, t_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drive one request and leave the bench observing cycle 1.
    task automatic request(input logic [3:0] addr, input logic [3:0] data);
        m_valid = 1'b1;
        m_addr  = addr;
        m_data  = data;
        tick();
        m_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; m_valid = 1'b0; m_addr = '0; m_data = '0;
        t_ack = '0; t_rdata = '0; t_rvalid = '0;
        do_reset();
        check_idle_outputs("reset");
        check_val("reset_taddr", {28'd0, t_addr}, 32'd0);
        check_val("reset_errcnt", {24'd0, err_count}, 32'd0);

        // Write to target 1, ack in cycle 3 without data
        request(4'h5, 4'hA);
        check_val("wr_tvalid_c1", {29'd0, t_valid}, 32'b010);
        check_val("wr_taddr", {28'd0, t_addr}, 32'h5);
        check_val("wr_tdata", {28'd0, t_data}, 32'hA);
        tick();
        check_val("wr_tvalid_c2", {29'd0, t_valid}, 32'b010);
        check_val("wr_noack_c2", {31'd0, m_ack}, 32'd0);
        tick();
        check_val("wr_tvalid_c3", {29'd0, t_valid}, 32'b010);
        t_ack = 3'b010; t_rdata = 12'h0F0; t_rvalid = 3'b000;
        tick();
        t_ack = '0; t_rdata = '0;
        check_val("wr_ack_c4", {31'd0, m_ack}, 32'd1);
        check_val("wr_err_c4", {31'd0, m_err}, 32'd0);
        check_val("wr_rvalid_c4", {31'd0, m_rvalid}, 32'd0);
        check_val("wr_rdata_c4", {28'd0, m_rdata}, 32'd0);
        check_val("wr_tvalid_c4", {29'd0, t_valid}, 32'd0);
        tick();
        check_val("wr_ack_done", {31'd0, m_ack}, 32'd0);

        // Selected-target ack outside REQ has no effect
        t_ack = 3'b010;
        tick();
        t_ack = '0;
        check_val("idle_ack_ignored", {31'd0, m_ack}, 32'd0);

        // Read from target 2, combinational ack in cycle 1
        request(4'hC, 4'h0);
        check_val("rd_tvalid_c1", {29'd0, t_valid}, 32'b100);
        t_ack = 3'b100; t_rdata = 12'h700; t_rvalid = 3'b100;
        tick();
        t_ack = '0; t_rdata = '0; t_rvalid = '0;
        check_val("rd_ack_c2", {31'd0, m_ack}, 32'd1);
        check_val("rd_rdata_c2", {28'd0, m_rdata}, 32'h7);
        check_val("rd_rvalid_c2", {31'd0, m_rvalid}, 32'd1);
        check_val("rd_err_c2", {31'd0, m_err}, 32'd0);
        check_val("rd_errcnt", {24'd0, err_count}, 32'd0);
        tick();

        // Timeout on target 0
        request(4'h2, 4'h3);
        for (int c = 1; c <= 8; c++) begin
            check_val($sformatf("to_tvalid_c%0d", c), {29'd0, t_valid}, 32'b001);
            check_val($sformatf("to_noack_c%0d", c), {31'd0, m_ack}, 32'd0);
            tick();
        end
        check_val("to_ack_c9", {31'd0, m_ack}, 32'd1);
        check_val("to_err_c9", {31'd0, m_err}, 32'd1);
        check_val("to_tvalid_c9", {29'd0, t_valid}, 32'd0);
        tick();
        check_val("to_errcnt", {24'd0, err_count}, 32'd1);

        // Back-to-back: 1 served, 6 buffered, 9 dropped
        do_reset();
        request(4'h1, 4'h1);
        check_val("b2b_tvalid_c1", {29'd0, t_valid}, 32'b001);
        check_val("b2b_ready_c1", {31'd0, m_ready}, 32'd1);
        m_valid = 1'b1; m_addr = 4'h6; m_data = 4'h2;
        tick();
        check_val("b2b_ready_c2", {31'd0, m_ready}, 32'd0);
        check_val("b2b_taddr_c2", {28'd0, t_addr}, 32'h1);
        m_addr = 4'h9; m_data = 4'h3;
        tick();
        m_valid = 1'b0;
        check_val("b2b_drop_cnt", {24'd0, err_count}, 32'd1);
        t_ack = 3'b001;
        tick();
        t_ack = '0;
        check_val("b2b_ack1", {31'd0, m_ack}, 32'd1);
        check_val("b2b_ready_resp", {31'd0, m_ready}, 32'd0);
        tick();
        check_val("b2b_tvalid_2nd", {29'd0, t_valid}, 32'b010);
        check_val("b2b_taddr_2nd", {28'd0, t_addr}, 32'h6);
        check_val("b2b_tdata_2nd", {28'd0, t_data}, 32'h2);
        check_val("b2b_ready_2nd", {31'd0, m_ready}, 32'd1);
        check_val("b2b_noack_2nd", {31'd0, m_ack}, 32'd0);
        t_ack = 3'b010;
        tick();
        t_ack = '0;
        check_val("b2b_ack2", {31'd0, m_ack}, 32'd1);
        check_val("b2b_err2", {31'd0, m_err}, 32'd0);
        tick();
        check_val("b2b_idle_tvalid", {29'd0, t_valid}, 32'd0);
        check_val("b2b_idle_ack", {31'd0, m_ack}, 32'd0);
        check_val("b2b_errcnt_end", {24'd0, err_count}, 32'd1);

        // Stray ack on target 2 during request to target 1
        do_reset();
        request(4'h5, 4'h0);
        t_ack = 3'b100;
        tick();
        t_ack = 3'b010; t_rdata = 12'h0B0; t_rvalid = 3'b010;
        check_val("stray_still_req", {29'd0, t_valid}, 32'b010);
        tick();
        t_ack = '0; t_rdata = '0; t_rvalid = '0;
        check_val("stray_ack", {31'd0, m_ack}, 32'd1);
        check_val("stray_err", {31'd0, m_err}, 32'd1);
        check_val("stray_rdata", {28'd0, m_rdata}, 32'hB);
        check_val("stray_rvalid", {31'd0, m_rvalid}, 32'd1);
        check_val("stray_errcnt", {24'd0, err_count}, 32'd1);
        tick();

        // Reset while in REQ with the slot full
        request(4'h0, 4'h5);
        m_valid = 1'b1; m_addr = 4'h4; m_data = 4'h6;
        tick();
        m_valid = 1'b0;
        check_val("rst_pre_ready", {31'd0, m_ready}, 32'd0);
        rst = 1'b1;
        tick();
        check_idle_outputs("rst_mid");
        check_val("rst_mid_taddr", {28'd0, t_addr}, 32'd0);
        check_val("rst_mid_tdata", {28'd0, t_data}, 32'd0);
        check_val("rst_mid_errcnt", {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        tick();
        check_val("rst_after_ack", {31'd0, m_ack}, 32'd0);
        check_val("rst_after_tvalid", {29'd0, t_valid}, 32'd0);
        tick();
        check_val("rst_after_ack2", {31'd0, m_ack}, 32'd0);
        check_val("rst_after_ready", {31'd0, m_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
